// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_pkg
// Brief    : Core-wide instruction-word constants and opcode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int c_INSTR_W = 16;
    localparam int c_OPC_MSB = 15;
    localparam int c_OPC_LSB = 13;
    localparam int c_OPC_W   = c_OPC_MSB - c_OPC_LSB + 1;

    typedef logic [c_INSTR_W-1:0] instr_t;
    typedef logic [c_OPC_W-1:0]   opcode_t;

    localparam opcode_t c_RFORMAT  = 3'b000;
    localparam opcode_t c_LOADW    = 3'b001;
    localparam opcode_t c_STOREW   = 3'b010;
    localparam opcode_t c_BRANCHEQ = 3'b011;
    localparam opcode_t c_JUMP     = 3'b100;
    localparam opcode_t c_JMPG     = 3'b111;

    function automatic opcode_t getOpcode(input instr_t instr);
        return instr[c_OPC_MSB:c_OPC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Brief    : Fetch-stage bundle: imem req/ack, redirect, IF/ID valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = 16
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    instr_t            imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic              if_ready;
    instr_t            if_instr;
    logic [ADDR_W-1:0] if_pc;
    opcode_t           if_opcode;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_if_id_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buf
// Brief    : Single-entry valid/ready register slice holding instr and pc.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buf
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  instr_t            i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_ready,
    output logic              o_valid,
    output instr_t            o_instr,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_valid;
    instr_t            r_instr;
    logic [ADDR_W-1:0] r_pc;

    // Loads only arrive when the slot drains this edge, so load wins over drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_load && !i_flush) begin
                r_instr <= i_instr;
                r_pc    <= i_pc;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : PC, imem req/ack fetch FSM with redirect/kill, IF/ID buffer.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_reqAddr;

    logic              w_bufFree;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_fire;
    logic              w_fill;
    logic [ADDR_W-1:0] w_pcInc;

    // WAIT and KILL keep the request up regardless of decode backpressure:
    // it was only raised when the buffer was guaranteed free for its data.
    assign w_bufFree = !bus.if_valid || bus.if_ready;
    assign w_req     = !rst && ((r_state == S_RUN) ? w_bufFree : 1'b1);
    assign w_addr    = (r_state == S_RUN) ? r_pc : r_reqAddr;
    assign w_fire    = w_req && bus.imem_ack;
    assign w_fill    = w_fire && !bus.redirect_valid && (r_state != S_KILL);
    assign w_pcInc   = w_addr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_PC;
            r_reqAddr <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc      <= bus.redirect_pc;
            r_reqAddr <= w_addr;
            r_state   <= (w_req && !bus.imem_ack) ? S_KILL : S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_fire) begin
                        r_pc <= w_pcInc;
                    end else if (w_req) begin
                        r_state   <= S_WAIT;
                        r_reqAddr <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_ack) begin
                        r_pc    <= w_pcInc;
                        r_state <= S_RUN;
                    end
                end
                S_KILL: begin
                    if (bus.imem_ack) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = w_addr;

    if_id_buf #(
        .ADDR_W (ADDR_W)
    ) u_ifIdBuf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect_valid),
        .i_load  (w_fill),
        .i_instr (bus.imem_rdata),
        .i_pc    (w_addr),
        .i_ready (bus.if_ready),
        .o_valid (bus.if_valid),
        .o_instr (bus.if_instr),
        .o_pc    (bus.if_pc)
    );

    assign bus.if_opcode = getOpcode(bus.if_instr);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed bench for instr_fetch with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int          AW     = 16;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic ackEn = 1'b0;
    bit   modelOn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_if #(.ADDR_W(AW)) bus();

    instr_fetch #(
        .ADDR_W   (AW),
        .RESET_PC (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory image: opcode field = low 3 address bits, so each word is traceable.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[2:0], a[12:0]};
    endfunction

    assign bus.imem_ack   = ackEn & bus.imem_req;
    assign bus.imem_rdata = memWord(bus.imem_addr);

    // Model: a pc, at most one outstanding request (possibly doomed), one slot.
    logic [15:0] mPc = RST_PC;
    logic [15:0] mOutAddr = '0;
    logic [15:0] mBufI = '0;
    logic [15:0] mBufP = '0;
    bit          mOut = 1'b0;
    bit          mKill = 1'b0;
    bit          mBufV = 1'b0;

    function automatic logic mReq();
        return !rst && (mOut || !mBufV || bus.if_ready);
    endfunction

    function automatic logic [15:0] mAddr();
        return mOut ? mOutAddr : mPc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : p_model
        logic        req;
        logic [15:0] a;
        req = mReq();
        a   = mAddr();
        if (rst) begin
            mPc = RST_PC; mOut = 0; mKill = 0; mBufV = 0; mBufI = '0; mBufP = '0;
        end else if (bus.redirect_valid) begin
            mPc      = bus.redirect_pc;
            mBufV    = 0;
            mOut     = req && !ackEn;
            mKill    = mOut;
            mOutAddr = a;
        end else begin
            if (mBufV && bus.if_ready) mBufV = 0;
            if (req && ackEn) begin
                if (!mKill) begin
                    mBufV = 1; mBufI = memWord(a); mBufP = a; mPc = a + 16'd1;
                end
                mOut = 0; mKill = 0;
            end else if (req) begin
                mOut = 1; mOutAddr = a;
            end
        end
    end

    always @(negedge clk) begin : p_compare
        if (modelOn) begin
            check("imem_req", 32'(bus.imem_req), 32'(mReq()));
            check("imem_addr", 32'(bus.imem_addr), 32'(mAddr()));
            check("if_valid", 32'(bus.if_valid), 32'(mBufV));
            if (mBufV) begin
                check("if_instr", 32'(bus.if_instr), 32'(mBufI));
                check("if_pc", 32'(bus.if_pc), 32'(mBufP));
                check("if_opcode", 32'(bus.if_opcode), 32'(mBufI[15:13]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        tick(); tick();
        modelOn = 1'b1;
        @(negedge clk);
        check("rst_if_valid", 32'(bus.if_valid), 0);
        check("rst_if_instr", 32'(bus.if_instr), 0);
        check("rst_if_pc", 32'(bus.if_pc), 0);
        check("rst_if_opcode", 32'(bus.if_opcode), 0);
        check("rst_imem_req", 32'(bus.imem_req), 0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'(RST_PC));

        // Streaming with single-cycle ack
        tick(); rst = 1'b0; ackEn = 1'b1;
        @(negedge clk);
        check("s_req0", 32'(bus.imem_req), 1);
        check("s_addr0", 32'(bus.imem_addr), 0);
        check("s_valid0", 32'(bus.if_valid), 0);
        tick(); @(negedge clk);
        check("s_addr1", 32'(bus.imem_addr), 1);
        check("s_pc0", 32'(bus.if_pc), 0);
        check("s_instr0", 32'(bus.if_instr), 32'h0000);
        tick(); @(negedge clk);
        check("s_addr2", 32'(bus.imem_addr), 2);
        check("s_pc1", 32'(bus.if_pc), 1);
        check("s_instr1", 32'(bus.if_instr), 32'h2001);
        check("s_opc1", 32'(bus.if_opcode), 1);
        tick(); @(negedge clk);
        check("s_addr3", 32'(bus.imem_addr), 3);
        check("s_pc2", 32'(bus.if_pc), 2);
        check("s_opc2", 32'(bus.if_opcode), 2);

        // Decode stalls three cycles with the buffer full
        tick(); bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req", 32'(bus.imem_req), 0);
            check("stall_pc", 32'(bus.if_pc), 3);
            check("stall_instr", 32'(bus.if_instr), 32'h6003);
            if (i < 2) tick();
        end
        tick(); bus.if_ready = 1'b1;
        @(negedge clk);
        check("unstall_req", 32'(bus.imem_req), 1);
        check("unstall_addr", 32'(bus.imem_addr), 4);
        tick(); @(negedge clk);
        check("unstall_pc", 32'(bus.if_pc), 4);

        // Ack delayed two cycles on address 5
        tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd5;
        tick(); bus.redirect_valid = 1'b0; ackEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ackEn = 1'b1;
            @(negedge clk);
            check("dly_req", 32'(bus.imem_req), 1);
            check("dly_addr", 32'(bus.imem_addr), 5);
            check("dly_valid", 32'(bus.if_valid), 0);
            if (i < 2) tick();
        end
        tick(); @(negedge clk);
        check("dly_valid1", 32'(bus.if_valid), 1);
        check("dly_pc", 32'(bus.if_pc), 5);
        check("dly_instr", 32'(bus.if_instr), 32'hA005);

        // Redirect to 0x0040 while request to 7 is outstanding
        tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd7;
        tick(); bus.redirect_valid = 1'b0; ackEn = 1'b0;
        @(negedge clk);
        check("kill_addr_a", 32'(bus.imem_addr), 7);
        tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
        @(negedge clk);
        check("kill_addr_b", 32'(bus.imem_addr), 7);
        tick(); bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("kill_addr_c", 32'(bus.imem_addr), 7);
        check("kill_req_c", 32'(bus.imem_req), 1);
        check("kill_valid_c", 32'(bus.if_valid), 0);
        tick(); ackEn = 1'b1;
        @(negedge clk);
        check("kill_addr_d", 32'(bus.imem_addr), 7);
        tick(); @(negedge clk);
        check("kill_valid_e", 32'(bus.if_valid), 0);
        check("kill_addr_e", 32'(bus.imem_addr), 32'h0040);
        tick(); @(negedge clk);
        check("kill_pc_f", 32'(bus.if_pc), 32'h0040);
        check("kill_valid_f", 32'(bus.if_valid), 1);

        // Redirect in the same cycle as the ack of 9
        tick(); bus.redirect_pc = 16'd9; bus.redirect_valid = 1'b1;
        tick(); bus.redirect_pc = 16'h0100;
        @(negedge clk);
        check("sameack_addr", 32'(bus.imem_addr), 9);
        tick(); bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("sameack_valid", 32'(bus.if_valid), 0);
        check("sameack_addr2", 32'(bus.imem_addr), 32'h0100);
        tick(); @(negedge clk);
        check("sameack_pc", 32'(bus.if_pc), 32'h0100);

        // PC wrap, then reset in the middle of a WAIT
        tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFF;
        tick(); bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr_ffff", 32'(bus.imem_addr), 32'hFFFF);
        tick(); @(negedge clk);
        check("wrap_addr_0", 32'(bus.imem_addr), 0);
        check("wrap_instr", 32'(bus.if_instr), 32'hFFFF);
        check("wrap_opc", 32'(bus.if_opcode), 7);
        tick(); ackEn = 1'b0;
        @(negedge clk);
        check("wait_addr", 32'(bus.imem_addr), 1);
        tick(); rst = 1'b1;
        @(negedge clk);
        check("midrst_req", 32'(bus.imem_req), 0);
        tick(); rst = 1'b0; ackEn = 1'b1;
        @(negedge clk);
        check("rst2_valid", 32'(bus.if_valid), 0);
        check("rst2_addr", 32'(bus.imem_addr), 32'(RST_PC));
        check("rst2_req", 32'(bus.imem_req), 1);
        tick(); @(negedge clk);
        check("rst2_addr1", 32'(bus.imem_addr), 1);
        check("rst2_pc", 32'(bus.if_pc), 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
